shift_pipe: RTL

Parametrised multi-bit shift register: a delay line of DEPTH stages, each WIDTH bits wide with a per-stage valid bit. It adds parallel load, rotate, clear, a clock enable, a selectable tap and occupancy count. It sits in datapaths as a configurable delay or alignment buffer and is the generalised replacement for fixed 4-stage 1-bit delay chains.

---
 rtl/shift_pipe.sv | 120 ++++++++++++
 1 files changed

// File: rtl/shift_pipe.sv
// shift_pipe: DEPTH-stage, WIDTH-bit delay line with a valid bit per stage.
// Supports shift, parallel load, rotate and clear under a clock enable, plus a selectable tap and an occupancy count.
module shift_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int TW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic [1:0]             mode,
    input  logic [WIDTH-1:0]       data_in,
    input  logic                   valid_in,
    input  logic [DEPTH*WIDTH-1:0] load_data,
    input  logic [TW-1:0]          tap_sel,
    output logic [WIDTH-1:0]       data_out,
    output logic                   valid_out,
    output logic [WIDTH-1:0]       tap_out,
    output logic                   tap_valid,
    output logic [DEPTH*WIDTH-1:0] par_out,
    output logic [CW-1:0]          count
);

    typedef enum logic [1:0] {
        MODE_SHIFT  = 2'b00,
        MODE_LOAD   = 2'b01,
        MODE_ROTATE = 2'b10,
        MODE_CLEAR  = 2'b11
    } mode_e;

    mode_e            modeSel;
    logic [WIDTH-1:0] stageData_q [DEPTH];
    logic [WIDTH-1:0] stageData_d [DEPTH];
    logic [DEPTH-1:0] stageValid_q;
    logic [DEPTH-1:0] stageValid_d;

    assign modeSel = mode_e'(mode);

    // Valid bits travel with the data but never gate its movement.
    always_comb begin
        stageData_d  = stageData_q;
        stageValid_d = stageValid_q;
        if (en) begin
            case (modeSel)
                MODE_SHIFT: begin
                    stageData_d[0] = data_in;
                    for (int i = 1; i < DEPTH; i++) begin
                        stageData_d[i] = stageData_q[i-1];
                    end
                    stageValid_d = {stageValid_q[DEPTH-2:0], valid_in};
                end
                MODE_LOAD: begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stageData_d[i] = load_data[i*WIDTH +: WIDTH];
                    end
                    stageValid_d = '1;
                end
                MODE_ROTATE: begin
                    stageData_d[0] = stageData_q[DEPTH-1];
                    for (int i = 1; i < DEPTH; i++) begin
                        stageData_d[i] = stageData_q[i-1];
                    end
                    stageValid_d = {stageValid_q[DEPTH-2:0], stageValid_q[DEPTH-1]};
                end
                MODE_CLEAR: begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stageData_d[i] = '0;
                    end
                    stageValid_d = '0;
                end
                default: begin
                    stageValid_d = stageValid_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stageData_q[i] <= '0;
            end
            stageValid_q <= '0;
        end else begin
            stageData_q  <= stageData_d;
            stageValid_q <= stageValid_d;
        end
    end

    assign data_out  = stageData_q[DEPTH-1];
    assign valid_out = stageValid_q[DEPTH-1];

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : gen_par
            assign par_out[g*WIDTH +: WIDTH] = stageData_q[g];
        end
    endgenerate

    // Out-of-range selects (only possible when DEPTH is not a power of two) read as empty.
    always_comb begin
        tap_out   = '0;
        tap_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (int'(tap_sel) == i) begin
                tap_out   = stageData_q[i];
                tap_valid = stageValid_q[i];
            end
        end
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count = count + CW'(stageValid_q[i]);
        end
    end

endmodule
